mem_io_ctrl: RTL and testbench
==============================

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, 15, memory wait cycles before an access is aborted with ERR (range 1..255).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 REQ  input  1  access request from the main control FSM; sampled only in IDLE.
REQ-005 R_W  input  1  0 = read, 1 = write; sampled with REQ.
REQ-006 MAR_OUT  input  16  access address; sampled with REQ.
REQ-007 MEM_R  input  1  memory ready, valid only while MEM_EN=1.
REQ-008 MEM_EN  output  1  memory enable.
REQ-009 MEM_WE  output  1  memory write enable.
REQ-010 INMUX_SEL  output  2  read-source select: 00 KBDR, 01 KBSR, 10 DSR, 11 memory.
REQ-011 MIO_EN  output  1  MDR source select: 0 = INMUX output, 1 = bus.
REQ-012 LD_MDR  output  1  MDR load strobe.
REQ-013 LD_KBSR, LD_DSR, LD_DDR  output  1 each  device register write strobes.
REQ-014 CLR_KBSR  output  1  clears the KBSR ready bit after a KBDR read.
REQ-015 BUSY  output  1  high in MEM and DEV.
REQ-016 DONE  output  1  one-cycle completion pulse.
REQ-017 ERR  output  1  valid only with DONE; 1 = memory timeout.

Function
REQ-018 States: IDLE, MEM, DEV, FIN; the encoding is held in the shared package.
REQ-019 IDLE with REQ=1: latch MAR_OUT and R_W; go to DEV if the address is xFE00 (KBSR), xFE02 (KBDR), xFE04 (DSR) or xFE06 (DDR); otherwise go to MEM.
REQ-020 REQ in MEM, DEV or FIN is ignored; there is no queueing.
REQ-021 MEM state outputs: MEM_EN=1, MEM_WE=latched R_W, INMUX_SEL=11, MIO_EN=~latched R_W.
REQ-022 MEM, read: LD_MDR=MEM_R, decoded combinationally in the same cycle.
REQ-023 MEM, MEM_R=1: go to FIN with ERR=0.
REQ-024 MEM, MEM_R=0: an 8-bit wait counter increments; when the counter equals MEM_TIMEOUT, go to FIN with ERR=1 and no LD_MDR.
REQ-025 The wait counter clears on every entry to MEM.
REQ-026 DEV lasts exactly one cycle, then goes to FIN with ERR=0.
REQ-027 DEV, read: MIO_EN=0, INMUX_SEL per address (KBDR 00, KBSR 01, DSR 10), LD_MDR=1; DDR read selects 10 and returns DSR, with no error.
REQ-028 DEV, KBDR read: CLR_KBSR=1 in the same cycle.
REQ-029 DEV, write: one-cycle strobe on LD_KBSR, LD_DSR or LD_DDR per address.
REQ-030 DEV, write to KBDR: no strobe and ERR=0.
REQ-031 FIN: DONE=1 for one cycle, ERR driven from a registered flag, then go to IDLE; minimum turnaround is 3 cycles for DEV and 3 cycles for MEM with MEM_R in the first cycle.
REQ-032 Idle output values: all strobes 0, MEM_EN=0, MEM_WE=0, INMUX_SEL=11, MIO_EN=1, BUSY=0, DONE=0, ERR=0.

Reset
REQ-033 RST_N low forces IDLE immediately, including mid-access, and drives every output to its idle value without waiting for CLK.
REQ-034 RST_N low clears the wait counter, the address/R_W latches and the ERR flag.
REQ-035 The first REQ is accepted on the first rising edge after RST_N deasserts.

Structure
REQ-036 Package lc3_pkg holds: the state enum; device addresses KBSR/KBDR/DSR/DDR; the INMUX_SEL encodings; the MIO_EN encodings.
REQ-037 Sub-module mem_io_decode is a purely combinational address decoder: address in, device-hit and INMUX_SEL out.
REQ-038 Nothing else is factored out of mem_io_ctrl.

Verification
REQ-039 Memory read x3000, MEM_R high 2 cycles after MEM entry -> MEM_EN high 3 cycles, LD_MDR pulse in the 3rd, DONE one cycle later, ERR=0.
REQ-040 Read xFE02 -> DEV cycle with INMUX_SEL=00, MIO_EN=0, LD_MDR=1, CLR_KBSR=1; DONE next cycle.
REQ-041 Write xFE06 -> single LD_DDR pulse, MEM_EN stays 0; write xFE02 -> no strobe, DONE with ERR=0.
REQ-042 Memory write, MEM_R held 0, MEM_TIMEOUT=15 -> MEM_WE high 16 cycles, then DONE with ERR=1 and no LD_MDR.
REQ-043 REQ held high continuously -> new accepts only in IDLE, one DONE per accept.
REQ-044 RST_N asserted in the 2nd MEM cycle -> MEM_EN drops asynchronously; next REQ after release behaves as from power-up.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 memory/IO access controller: state encoding,
// memory-mapped device addresses and the MDR source-select encodings.
package lc3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DEV  = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  localparam logic [1:0] INMUX_KBDR = 2'b00;
  localparam logic [1:0] INMUX_KBSR = 2'b01;
  localparam logic [1:0] INMUX_DSR  = 2'b10;
  localparam logic [1:0] INMUX_MEM  = 2'b11;

  localparam logic MIO_INMUX = 1'b0;
  localparam logic MIO_BUS   = 1'b1;

endpackage

// File: rtl/mem_io_decode.sv
// Combinational device-address decoder: flags device-register hits and picks
// the INMUX source for a read of that address.
module mem_io_decode
  import lc3_pkg::*;
(
  input  logic [15:0] addr,
  output logic        dev_hit,
  output logic [1:0]  inmux_sel
);

  always_comb begin
    dev_hit   = 1'b1;
    inmux_sel = INMUX_MEM;
    case (addr)
      ADDR_KBSR: inmux_sel = INMUX_KBSR;
      ADDR_KBDR: inmux_sel = INMUX_KBDR;
      // DDR is write-only; a read of it returns the display status
      ADDR_DSR,
      ADDR_DDR:  inmux_sel = INMUX_DSR;
      default:   dev_hit   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_io_ctrl.sv
// Memory/IO access controller: runs one memory or device-register access per
// request, with a bounded wait on memory ready and a one-cycle DONE/ERR report.
module mem_io_ctrl
  import lc3_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        r_w,
  input  logic [15:0] mar_out,
  input  logic        mem_r,
  output logic        mem_en,
  output logic        mem_we,
  output logic [1:0]  inmux_sel,
  output logic        mio_en,
  output logic        ld_mdr,
  output logic        ld_kbsr,
  output logic        ld_dsr,
  output logic        ld_ddr,
  output logic        clr_kbsr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

  state_t      state, state_nxt;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [7:0]  wait_cnt;
  logic        err_q;

  logic [15:0] dec_addr;
  logic        dec_hit;
  logic [1:0]  dec_sel;

  // In IDLE the live address steers the accept decision; afterwards the latch
  assign dec_addr = (state == ST_IDLE) ? mar_out : addr_q;

  mem_io_decode u_decode (
    .addr      (dec_addr),
    .dev_hit   (dec_hit),
    .inmux_sel (dec_sel)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      rw_q     <= 1'b0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req) begin
          addr_q   <= mar_out;
          rw_q     <= r_w;
          wait_cnt <= '0;
          err_q    <= 1'b0;
        end
        ST_MEM: if (!mem_r) begin
          if (wait_cnt == TIMEOUT_CNT) err_q <= 1'b1;
          else                         wait_cnt <= wait_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req) state_nxt = dec_hit ? ST_DEV : ST_MEM;
      // Ready wins over timeout when both land in the same cycle
      ST_MEM:  if (mem_r || (wait_cnt == TIMEOUT_CNT)) state_nxt = ST_FIN;
      ST_DEV:  state_nxt = ST_FIN;
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    inmux_sel = INMUX_MEM;
    mio_en    = MIO_BUS;
    ld_mdr    = 1'b0;
    ld_kbsr   = 1'b0;
    ld_dsr    = 1'b0;
    ld_ddr    = 1'b0;
    clr_kbsr  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_MEM: begin
        busy   = 1'b1;
        mem_en = 1'b1;
        mem_we = rw_q;
        mio_en = ~rw_q;
        ld_mdr = mem_r & ~rw_q;
      end
      ST_DEV: begin
        busy = 1'b1;
        if (!rw_q) begin
          mio_en    = MIO_INMUX;
          inmux_sel = dec_sel;
          ld_mdr    = 1'b1;
          clr_kbsr  = (addr_q == ADDR_KBDR);
        end else begin
          ld_kbsr = (addr_q == ADDR_KBSR);
          ld_dsr  = (addr_q == ADDR_DSR);
          ld_ddr  = (addr_q == ADDR_DDR);
        end
      end
      ST_FIN: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: stimulus pushes the expected transaction
// summary, a monitor accumulates DUT activity and checks it on every DONE.
module tb_mem_io_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        r_w = 1'b0;
  logic [15:0] mar_out = 16'h0000;
  logic        mem_r = 1'b0;
  logic        mem_en, mem_we, mio_en, ld_mdr;
  logic        ld_kbsr, ld_dsr, ld_ddr, clr_kbsr, busy, done, err;
  logic [1:0]  inmux_sel;

  int checks = 0;
  int errors = 0;
  int cur_delay = 0;

  typedef struct {
    int err; int busy; int en; int we; int ld;
    int sel; int mio; int kbsr; int dsr; int ddr; int clr;
  } exp_t;

  exp_t exp_q[$];

  mem_io_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .r_w(r_w), .mar_out(mar_out),
    .mem_r(mem_r), .mem_en(mem_en), .mem_we(mem_we), .inmux_sel(inmux_sel),
    .mio_en(mio_en), .ld_mdr(ld_mdr), .ld_kbsr(ld_kbsr), .ld_dsr(ld_dsr),
    .ld_ddr(ld_ddr), .clr_kbsr(clr_kbsr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_mem_en"}, int'(mem_en), 0);
    chk({tag, "_mem_we"}, int'(mem_we), 0);
    chk({tag, "_inmux"}, int'(inmux_sel), 3);
    chk({tag, "_mio_en"}, int'(mio_en), 1);
    chk({tag, "_ld_mdr"}, int'(ld_mdr), 0);
    chk({tag, "_strobes"}, int'({ld_kbsr, ld_dsr, ld_ddr, clr_kbsr}), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // Reference model: what one accepted access must look like end to end.
  // d = MEM-cycle index at which memory answers ready.
  function automatic exp_t model(input logic [15:0] a, input bit w, input int d);
    exp_t e;
    int   cyc;
    e = '{err:0, busy:0, en:0, we:0, ld:0, sel:3, mio:1, kbsr:0, dsr:0, ddr:0, clr:0};
    if (a == 16'hFE00 || a == 16'hFE02 || a == 16'hFE04 || a == 16'hFE06) begin
      e.busy = 1;
      if (!w) begin
        e.ld  = 1;
        e.mio = 0;
        e.sel = (a == 16'hFE02) ? 0 : (a == 16'hFE00) ? 1 : 2;
        e.clr = (a == 16'hFE02) ? 1 : 0;
      end else begin
        e.kbsr = (a == 16'hFE00) ? 1 : 0;
        e.dsr  = (a == 16'hFE04) ? 1 : 0;
        e.ddr  = (a == 16'hFE06) ? 1 : 0;
      end
    end else begin
      e.err  = (d > TO) ? 1 : 0;
      cyc    = (d > TO) ? TO + 1 : d + 1;
      e.busy = cyc;
      e.en   = cyc;
      e.we   = w ? cyc : 0;
      e.ld   = (!w && d <= TO) ? 1 : 0;
      e.sel  = 3;
      e.mio  = w ? 0 : 1;
    end
    return e;
  endfunction

  // Memory responder: raises ready in MEM cycle number cur_delay
  initial begin
    int mcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_en) begin
        mem_r = (mcnt == cur_delay);
        mcnt++;
      end else begin
        mem_r = 1'b0;
        mcnt  = 0;
      end
    end
  end

  // Monitor: accumulate activity, compare against the scoreboard on DONE
  initial begin
    int   n_busy, n_en, n_we, n_ld, n_kbsr, n_dsr, n_ddr, n_clr, sel_ld, mio_ld;
    exp_t e;
    n_busy = 0; n_en = 0; n_we = 0; n_ld = 0;
    n_kbsr = 0; n_dsr = 0; n_ddr = 0; n_clr = 0; sel_ld = 3; mio_ld = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_busy = 0; n_en = 0; n_we = 0; n_ld = 0;
        n_kbsr = 0; n_dsr = 0; n_ddr = 0; n_clr = 0; sel_ld = 3; mio_ld = 1;
      end else begin
        if (busy)     n_busy++;
        if (mem_en)   n_en++;
        if (mem_we)   n_we++;
        if (ld_kbsr)  n_kbsr++;
        if (ld_dsr)   n_dsr++;
        if (ld_ddr)   n_ddr++;
        if (clr_kbsr) n_clr++;
        if (ld_mdr) begin
          n_ld++;
          sel_ld = int'(inmux_sel);
          mio_ld = int'(mio_en);
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("err", int'(err), e.err);
            chk("busy_cycles", n_busy, e.busy);
            chk("mem_en_cycles", n_en, e.en);
            chk("mem_we_cycles", n_we, e.we);
            chk("ld_mdr_pulses", n_ld, e.ld);
            if (e.ld > 0) begin
              chk("inmux_at_ld", sel_ld, e.sel);
              chk("mio_at_ld", mio_ld, e.mio);
            end
            chk("ld_kbsr", n_kbsr, e.kbsr);
            chk("ld_dsr", n_dsr, e.dsr);
            chk("ld_ddr", n_ddr, e.ddr);
            chk("clr_kbsr", n_clr, e.clr);
          end
          n_busy = 0; n_en = 0; n_we = 0; n_ld = 0;
          n_kbsr = 0; n_dsr = 0; n_ddr = 0; n_clr = 0; sel_ld = 3; mio_ld = 1;
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic issue(input logic [15:0] a, input bit w, input int d);
    wait_drain();
    @(negedge clk);
    cur_delay = d;
    mar_out   = a;
    r_w       = w;
    req       = 1'b1;
    exp_q.push_back(model(a, w, d));
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  initial begin
    logic [15:0] a;
    bit          w;
    #3;
    check_idle("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue(16'h3000, 1'b0, 2);
    issue(16'hFE02, 1'b0, 0);
    issue(16'hFE06, 1'b1, 0);
    issue(16'hFE02, 1'b1, 0);
    issue(16'h4000, 1'b1, 99);
    issue(16'hFE00, 1'b0, 0);
    issue(16'hFE04, 1'b1, 0);
    issue(16'hFE06, 1'b0, 0);
    issue(16'h1234, 1'b0, TO);

    // REQ held high: accepts only in IDLE, address changes elsewhere ignored
    wait_drain();
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      req = 1'b1;
      r_w = 1'b0;
      mar_out = (i % 3 == 0) ? 16'hFE02 : 16'h3000;
      if (i % 3 == 0) exp_q.push_back(model(16'hFE02, 1'b0, 0));
      @(negedge clk);
    end
    req = 1'b0;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) a = 16'hFE00 + 16'($urandom_range(0, 3) * 2);
      else                           a = 16'($urandom);
      w = bit'($urandom_range(0, 1));
      issue(a, w, $urandom_range(0, TO + 5));
    end

    // Reset in the 2nd MEM cycle of a read that never gets ready
    wait_drain();
    @(negedge clk);
    cur_delay = 99;
    mar_out   = 16'h5000;
    r_w       = 1'b0;
    req       = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    chk("pre_reset_mem_en", int'(mem_en), 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_idle("async_reset");
    exp_q.delete();
    @(negedge clk);
    mar_out = 16'hFE06;
    r_w     = 1'b1;
    req     = 1'b1;
    exp_q.push_back(model(16'hFE06, 1'b1, 0));
    rst_n   = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    issue(16'h3000, 1'b0, 0);

    wait_drain();
    repeat (3) @(negedge clk);
    check_idle("final_idle");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
